// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch stage sitting directly in front of the instruction memory. The PC is
// driven out as the fetch address. After READ_CYCLES rising edges the returned
// word is captured, together with its PC, into a 2-entry queue. The queue head
// is offered to decode with a valid/ready handshake. A redirect flushes the
// queue and any in-flight fetch, then restarts fetching at the new target.
//
// Ports:
//   CLK          in   1   system clock, rising edge active
//   Reset        in   1   asynchronous active-high reset
//   IMemAddress  out  64  fetch address (current PC)
//   IMemData     in   32  instruction word from memory
//   Redirect     in   1   flush and restart at RedirectPC
//   RedirectPC   in   64  redirect target (low two bits forced to zero)
//   DecodeReady  in   1   decode accepts the head entry
//   InstrValid   out  1   queue head is valid
//   Instruction  out  32  head instruction word (zero when not valid)
//   InstrPC      out  64  head instruction PC (zero when not valid)
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          READ_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic [63:0] IMemAddress,
    input  logic [31:0] IMemData,
    input  logic        Redirect,
    input  logic [63:0] RedirectPC,
    input  logic        DecodeReady,
    output logic        InstrValid,
    output logic [31:0] Instruction,
    output logic [63:0] InstrPC
);

    typedef enum logic [0:0] {
        ST_WAIT = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(READ_CYCLES - 1);

    state_t      state_r;
    logic [63:0] pc_r;
    logic [3:0]  cnt_r;
    logic [63:0] q_pc_r    [0:1];
    logic [31:0] q_instr_r [0:1];
    logic        head_r;
    logic        tail_r;
    logic [1:0]  count_r;

    logic        not_full_s;
    logic        capture_s;
    logic        dequeue_s;

    // Capture/dequeue decisions use the occupancy at the start of the cycle,
    // so a same-cycle dequeue never makes room for a same-cycle capture.
    always_comb begin
        not_full_s = (count_r != 2'd2);
        dequeue_s  = (count_r != 2'd0) && DecodeReady;
        capture_s  = 1'b0;
        case (state_r)
            ST_WAIT: begin
                if ((cnt_r == CNT_LAST) && not_full_s) begin
                    capture_s = 1'b1;
                end else begin
                    capture_s = 1'b0;
                end
            end
            ST_HOLD: begin
                capture_s = not_full_s;
            end
            default: begin
                capture_s = 1'b0;
            end
        endcase
    end

    // Fetch FSM, wait counter, PC and queue state; redirect overrides all.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_r      <= ST_WAIT;
            pc_r         <= RESET_PC;
            cnt_r        <= 4'd0;
            head_r       <= 1'b0;
            tail_r       <= 1'b0;
            count_r      <= 2'd0;
            q_pc_r[0]    <= 64'h0;
            q_pc_r[1]    <= 64'h0;
            q_instr_r[0] <= 32'h0;
            q_instr_r[1] <= 32'h0;
        end else if (Redirect) begin
            state_r <= ST_WAIT;
            pc_r    <= RedirectPC & ~64'h3;
            cnt_r   <= 4'd0;
            head_r  <= 1'b0;
            tail_r  <= 1'b0;
            count_r <= 2'd0;
        end else begin
            case (state_r)
                ST_WAIT: begin
                    if (cnt_r != CNT_LAST) begin
                        cnt_r <= cnt_r + 4'd1;
                    end else if (capture_s) begin
                        cnt_r <= 4'd0;
                    end else begin
                        // Memory data is ready but the queue is full: park.
                        state_r <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (capture_s) begin
                        state_r <= ST_WAIT;
                        cnt_r   <= 4'd0;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r <= ST_WAIT;
                    cnt_r   <= 4'd0;
                end
            endcase

            if (capture_s) begin
                q_pc_r[tail_r]    <= pc_r;
                q_instr_r[tail_r] <= IMemData;
                tail_r            <= ~tail_r;
                pc_r              <= pc_r + 64'd4;   // wraps modulo 2^64
            end

            if (dequeue_s) begin
                head_r <= ~head_r;
            end

            case ({capture_s, dequeue_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Outputs decode straight from state registers; nothing from inputs.
    always_comb begin
        IMemAddress = pc_r;
        InstrValid  = (count_r != 2'd0);
        if (count_r != 2'd0) begin
            Instruction = q_instr_r[head_r];
            InstrPC     = q_pc_r[head_r];
        end else begin
            Instruction = 32'h0;
            InstrPC     = 64'h0;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [63:0] IMemAddress;
    logic [31:0] IMemData;
    logic        Redirect;
    logic [63:0] RedirectPC;
    logic        DecodeReady;
    logic        InstrValid;
    logic [31:0] Instruction;
    logic [63:0] InstrPC;

    // Second instance for the PC wrap scenario
    logic        w_Reset;
    logic [63:0] w_IMemAddress;
    logic [31:0] w_IMemData;
    logic        w_Redirect;
    logic [63:0] w_RedirectPC;
    logic        w_DecodeReady;
    logic        w_InstrValid;
    logic [31:0] w_Instruction;
    logic [63:0] w_InstrPC;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem(input logic [63:0] a);
        case (a)
            64'h0:   mem = 32'hF84003E9;
            64'h4:   mem = 32'hF84083EA;
            64'h1C:  mem = 32'hB40000AC;
            default: mem = 32'hD503201F;
        endcase
    endfunction

    assign IMemData   = mem(IMemAddress);
    assign w_IMemData = mem(w_IMemAddress);

    instruction_fetch_unit #(.RESET_PC(64'h0), .READ_CYCLES(2)) dut (
        .CLK(CLK), .Reset(Reset), .IMemAddress(IMemAddress), .IMemData(IMemData),
        .Redirect(Redirect), .RedirectPC(RedirectPC), .DecodeReady(DecodeReady),
        .InstrValid(InstrValid), .Instruction(Instruction), .InstrPC(InstrPC)
    );

    instruction_fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .READ_CYCLES(2)) dut_wrap (
        .CLK(CLK), .Reset(w_Reset), .IMemAddress(w_IMemAddress), .IMemData(w_IMemData),
        .Redirect(w_Redirect), .RedirectPC(w_RedirectPC), .DecodeReady(w_DecodeReady),
        .InstrValid(w_InstrValid), .Instruction(w_Instruction), .InstrPC(w_InstrPC)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; DecodeReady = 1'b1; Redirect = 1'b0; RedirectPC = 64'h0;
        tick(); tick();
        checks++;
        if (IMemAddress !== 64'h0) begin errors++; $display("FAIL reset_addr got=%h exp=%h", IMemAddress, 64'h0); end
        checks++;
        if (InstrValid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", InstrValid); end
        checks++;
        if (Instruction !== 32'h0 || InstrPC !== 64'h0) begin errors++; $display("FAIL reset_head got=%h/%h exp=0/0", InstrPC, Instruction); end
        Reset = 1'b0;
        tick();
        checks++;
        if (InstrValid !== 1'b0 || IMemAddress !== 64'h0) begin errors++; $display("FAIL stream_e1 got=%b/%h exp=0/0", InstrValid, IMemAddress); end
        tick();
        checks++;
        if (InstrValid !== 1'b1 || InstrPC !== 64'h0 || Instruction !== 32'hF84003E9) begin
            errors++; $display("FAIL stream_first got=%b %h %h exp=1 0 F84003E9", InstrValid, InstrPC, Instruction);
        end
        checks++;
        if (IMemAddress !== 64'h4) begin errors++; $display("FAIL stream_addr4 got=%h exp=4", IMemAddress); end
        tick();
        checks++;
        if (InstrValid !== 1'b0) begin errors++; $display("FAIL stream_drain got=%b exp=0", InstrValid); end
        tick();
        checks++;
        if (InstrValid !== 1'b1 || InstrPC !== 64'h4 || Instruction !== 32'hF84083EA) begin
            errors++; $display("FAIL stream_second got=%b %h %h exp=1 4 F84083EA", InstrValid, InstrPC, Instruction);
        end
    endtask

    task automatic test_backpressure();
        Reset = 1'b1; DecodeReady = 1'b0;
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (InstrValid !== 1'b1 || InstrPC !== 64'h0 || Instruction !== 32'hF84003E9) begin
            errors++; $display("FAIL bp_head got=%b %h %h exp=1 0 F84003E9", InstrValid, InstrPC, Instruction);
        end
        checks++;
        if (IMemAddress !== 64'h8) begin errors++; $display("FAIL bp_addr got=%h exp=8", IMemAddress); end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (IMemAddress !== 64'h8 || InstrPC !== 64'h0 || InstrValid !== 1'b1) begin
            errors++; $display("FAIL bp_hold got=%h %h %b exp=8 0 1", IMemAddress, InstrPC, InstrValid);
        end
        DecodeReady = 1'b1;
        tick();
        DecodeReady = 1'b0;
        checks++;
        if (InstrValid !== 1'b1 || InstrPC !== 64'h4 || Instruction !== 32'hF84083EA) begin
            errors++; $display("FAIL bp_deq got=%b %h %h exp=1 4 F84083EA", InstrValid, InstrPC, Instruction);
        end
        checks++;
        if (IMemAddress !== 64'h8) begin errors++; $display("FAIL bp_no_passthru got=%h exp=8", IMemAddress); end
        tick();
        checks++;
        if (IMemAddress !== 64'hC || InstrPC !== 64'h4) begin
            errors++; $display("FAIL bp_resume got=%h %h exp=c 4", IMemAddress, InstrPC);
        end
    endtask

    task automatic test_redirect();
        // Queue now holds 0x4 and 0x8
        Redirect = 1'b1; RedirectPC = 64'h1C;
        tick();
        Redirect = 1'b0;
        checks++;
        if (InstrValid !== 1'b0 || IMemAddress !== 64'h1C) begin
            errors++; $display("FAIL redir_flush got=%b %h exp=0 1c", InstrValid, IMemAddress);
        end
        checks++;
        if (Instruction !== 32'h0 || InstrPC !== 64'h0) begin
            errors++; $display("FAIL redir_zero got=%h %h exp=0 0", InstrPC, Instruction);
        end
        tick();
        checks++;
        if (InstrValid !== 1'b0) begin errors++; $display("FAIL redir_gap got=%b exp=0", InstrValid); end
        tick();
        checks++;
        if (InstrValid !== 1'b1 || InstrPC !== 64'h1C || Instruction !== 32'hB40000AC) begin
            errors++; $display("FAIL redir_target got=%b %h %h exp=1 1c B40000AC", InstrValid, InstrPC, Instruction);
        end
    endtask

    task automatic test_unaligned_collision();
        tick();   // wait counter reaches its last value; next edge captures 0x20
        checks++;
        if (IMemAddress !== 64'h20) begin errors++; $display("FAIL coll_pre got=%h exp=20", IMemAddress); end
        Redirect = 1'b1; RedirectPC = 64'h1E;
        tick();
        Redirect = 1'b0;
        checks++;
        if (IMemAddress !== 64'h1C || InstrValid !== 1'b0) begin
            errors++; $display("FAIL coll_drop got=%h %b exp=1c 0", IMemAddress, InstrValid);
        end
        tick();
        checks++;
        if (InstrValid !== 1'b0) begin errors++; $display("FAIL coll_gap got=%b exp=0", InstrValid); end
        tick();
        checks++;
        if (InstrValid !== 1'b1 || InstrPC !== 64'h1C || Instruction !== 32'hB40000AC) begin
            errors++; $display("FAIL coll_target got=%b %h %h exp=1 1c B40000AC", InstrValid, InstrPC, Instruction);
        end
    endtask

    task automatic test_async_reset();
        // One entry queued, DecodeReady low: fill to two then park in HOLD
        tick(); tick(); tick();
        checks++;
        if (InstrValid !== 1'b1 || IMemAddress !== 64'h24 || InstrPC !== 64'h1C) begin
            errors++; $display("FAIL ar_hold got=%b %h %h exp=1 24 1c", InstrValid, IMemAddress, InstrPC);
        end
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if (IMemAddress !== 64'h0 || InstrValid !== 1'b0 || Instruction !== 32'h0 || InstrPC !== 64'h0) begin
            errors++; $display("FAIL ar_immediate got=%h %b %h %h exp=0 0 0 0", IMemAddress, InstrValid, Instruction, InstrPC);
        end
        #2;
        Reset = 1'b0;
        DecodeReady = 1'b1;
        tick();
        checks++;
        if (InstrValid !== 1'b0) begin errors++; $display("FAIL ar_resume_gap got=%b exp=0", InstrValid); end
        tick();
        checks++;
        if (InstrValid !== 1'b1 || InstrPC !== 64'h0 || Instruction !== 32'hF84003E9) begin
            errors++; $display("FAIL ar_resume got=%b %h %h exp=1 0 F84003E9", InstrValid, InstrPC, Instruction);
        end
    endtask

    task automatic test_wrap();
        checks++;
        if (w_IMemAddress !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            errors++; $display("FAIL wrap_reset got=%h exp=fffffffffffffffc", w_IMemAddress);
        end
        w_Reset = 1'b0;
        tick(); tick();
        checks++;
        if (w_IMemAddress !== 64'h0) begin errors++; $display("FAIL wrap_addr got=%h exp=0", w_IMemAddress); end
        checks++;
        if (w_InstrValid !== 1'b1 || w_InstrPC !== 64'hFFFF_FFFF_FFFF_FFFC || w_Instruction !== 32'hD503201F) begin
            errors++; $display("FAIL wrap_head got=%b %h %h exp=1 fffffffffffffffc D503201F", w_InstrValid, w_InstrPC, w_Instruction);
        end
    endtask

    initial begin
        w_Reset = 1'b1; w_Redirect = 1'b0; w_RedirectPC = 64'h0; w_DecodeReady = 1'b0;
        test_reset();
        test_backpressure();
        test_redirect();
        test_unaligned_collision();
        test_async_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage directly upstream of the instruction memory. Holds the program counter and drives the 64-bit fetch address. Waits a fixed number of cycles for the memory read to settle, then captures each 32-bit instruction with its PC into a 2-entry queue. Presents the queue head to decode with a valid/ready handshake, and supports redirect (taken branch/CBZ) with flush.

## Interface
- RESET_PC, 64'h0, PC loaded on reset.
- READ_CYCLES, 2, rising edges from address change to data capture; legal range 1..15.
- CLK  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- IMemAddress  out  64  fetch address to instruction memory; always equals the current PC.
- IMemData  in  32  instruction word returned by the instruction memory.
- Redirect  in  1  single-cycle pulse: discard queued/in-flight fetches and restart at RedirectPC.
- RedirectPC  in  64  new fetch target, sampled when Redirect=1.
- DecodeReady  in  1  decode accepts the head entry this cycle.
- InstrValid  out  1  queue non-empty; head is valid.
- Instruction  out  32  head instruction word.
- InstrPC  out  64  PC of head instruction.

## Operation
- **State:**
  - PC (64b).
  - Wait counter cnt (4b).
  - Queue of 2 entries {pc, instr}, with head pointer, tail pointer and count (0..2).
  - FSM with states WAIT and HOLD.
- **WAIT state:**
  - IMemAddress = PC is held stable.
  - While cnt < READ_CYCLES-1, cnt increments by 1.
  - When cnt == READ_CYCLES-1 and count < 2 at the edge: capture. The queue tail gets {PC, IMemData}, PC <= PC+4, cnt <= 0, and the FSM stays in WAIT.
  - When cnt == READ_CYCLES-1 and count == 2: go to HOLD. PC and cnt are unchanged.
- **HOLD state:** capture happens on the first edge where count < 2 at the start of the cycle, then return to WAIT with cnt=0. A dequeue in the same cycle does not create space for that cycle's capture; no pass-through.
- **Dequeue:** when InstrValid && DecodeReady at the edge, the head advances and count decrements. Capture and dequeue in the same cycle leave count unchanged.
- **Redirect (highest priority):**
  - Sets count <= 0, pointers <= 0, PC <= {RedirectPC[63:2], 2'b00}, cnt <= 0, state <= WAIT.
  - Suppresses any capture or dequeue in that cycle.
  - RedirectPC is always word-aligned by forcing bits [1:0] to zero.
- **PC arithmetic:** PC+4 is modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC wraps to 64'h0.
- **Outputs:**
  - InstrValid = (count != 0).
  - Instruction and InstrPC come from the head entry. When InstrValid=0 they are 32'h0 and 64'h0.
  - All outputs are derived from registers only; there is no combinational path from inputs to outputs.
- **Reset (asynchronous, any time, including mid-wait or in HOLD):**
  - PC=RESET_PC, cnt=0, queue empty, state WAIT.
  - IMemAddress=RESET_PC, InstrValid=0, Instruction=0, InstrPC=0.

## Timing
- **First capture:** with address A presented after reset deassertion or after a redirect edge, capture occurs on the READ_CYCLES-th subsequent rising edge. InstrValid rises on that same edge.
- **Throughput:** with DecodeReady held high, one instruction every READ_CYCLES cycles. Queue occupancy stays ≤1.
- **Redirect latency:**
  - IMemAddress shows the new target one edge after the Redirect pulse.
  - InstrValid is 0 from that edge until the first capture at the new target, READ_CYCLES edges later.
- **Backpressure:** with DecodeReady=0, exactly 2 entries are captured, then the unit sits in HOLD with IMemAddress = the next PC. The first capture after DecodeReady returns to 1 occurs one edge after count drops below 2.
- **Simultaneous events:**
  - Redirect with a capture edge: the capture is dropped.
  - Redirect with a dequeue: the dequeue is dropped; decode must treat the head as squashed.
- **Data sampling:** IMemData is sampled only on capture edges. It may be X at all other times without effect.

## Test plan
- **Reset and stream:** Reset pulse; READ_CYCLES=2; memory model loaded with 0x000:F84003E9, 0x004:F84083EA; DecodeReady=1.
  - IMemAddress=0 during reset.
  - Head {0x0, F84003E9} is valid at the 2nd edge after release.
  - Head {0x4, F84083EA} is valid at the 4th edge.
- **Backpressure:** DecodeReady=0 from reset.
  - Queue holds PCs 0x0 and 0x4; IMemAddress stays 0x8; InstrValid stays 1 with head 0x0.
  - Raise DecodeReady for 1 cycle: head becomes 0x4, and the 0x8 word is captured one edge later.
- **Redirect/flush:** with 2 entries queued, pulse Redirect with RedirectPC=0x1C.
  - Next edge: InstrValid=0, IMemAddress=0x1C.
  - 2 edges later: head {0x1C, B40000AC}.
- **Unaligned redirect and collision:** RedirectPC=0x1E asserted on the same edge as a scheduled capture.
  - The capture is discarded and IMemAddress=0x1C.
  - The next valid InstrPC is 0x1C.
- **Wrap:** RESET_PC=64'hFFFF_FFFF_FFFF_FFFC; after the first capture, IMemAddress=0 and InstrPC=64'hFFFF_FFFF_FFFF_FFFC.
- **Async reset mid-operation:** assert Reset between edges while in HOLD. All outputs return to reset values immediately, without waiting for an edge. Normal fetch resumes from RESET_PC after release.
